// File: rtl/mult_pkg.sv
// Shared sizing, state encoding and operand helpers for the iterative
// 32x32 multiplier.
package mult_pkg;

  localparam int MULT_WIDTH  = 32;
  localparam int MULT_BPC    = 4;
  localparam int MULT_ITERS  = MULT_WIDTH / MULT_BPC;
  localparam int MULT_CNT_W  = 3;
  localparam int MULT_PROD_W = 2 * MULT_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mult_state_e;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [MULT_WIDTH-1:0] mult_mag(
    input logic [MULT_WIDTH-1:0] v,
    input logic                  is_signed
  );
    return (is_signed && v[MULT_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_pp4_adder.sv
// Combinational slice: four partial products of mcand, shifted into place
// for the current iteration and reduced with a two-level adder tree.
module mult_pp4_adder
  import mult_pkg::*;
(
  input  logic [MULT_WIDTH-1:0]  mcand_i,
  input  logic [MULT_BPC-1:0]    bits_i,
  input  logic [MULT_CNT_W-1:0]  cnt_i,
  output logic [MULT_PROD_W-1:0] sum_o
);

  logic [MULT_PROD_W-1:0] s [MULT_BPC];
  logic [MULT_PROD_W-1:0] add1_0_1;
  logic [MULT_PROD_W-1:0] add1_2_3;
  logic [5:0]             base_shift;

  assign base_shift = {1'b0, cnt_i, 2'b00};

  always_comb begin
    for (int i = 0; i < MULT_BPC; i++) begin
      s[i] = ({{MULT_WIDTH{1'b0}}, mcand_i} & {MULT_PROD_W{bits_i[i]}})
             << (6'(i) + base_shift);
    end
  end

  assign add1_0_1 = s[0] + s[1];
  assign add1_2_3 = s[2] + s[3];
  assign sum_o    = add1_0_1 + add1_2_3;

endmodule

// File: rtl/mult_iter4.sv
// Iterative sign-magnitude multiplier: 4 multiplier bits per cycle, 8 busy
// cycles per product, result negated on the final iteration when needed.
module mult_iter4
  import mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mult_signed,
  input  logic [MULT_WIDTH-1:0]  a,
  input  logic [MULT_WIDTH-1:0]  b,
  output logic                   busy,
  output logic [MULT_PROD_W-1:0] z
);

  localparam logic [MULT_CNT_W-1:0] LAST_CNT = MULT_CNT_W'(MULT_ITERS - 1);

  mult_state_e            state_q, state_d;
  logic [MULT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [MULT_WIDTH-1:0]  mcand_q, mcand_d;
  logic [MULT_WIDTH-1:0]  mplier_q, mplier_d;
  logic                   neg_q, neg_d;
  logic [MULT_PROD_W-1:0] acc_q, acc_d;
  logic [MULT_PROD_W-1:0] z_q, z_d;

  logic [MULT_PROD_W-1:0] partial;
  logic [MULT_PROD_W-1:0] acc_sum;

  // The multiplier register shifts right each iteration, so its low nibble
  // always holds the next four bits to consume.
  mult_pp4_adder u_pp4 (
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[MULT_BPC-1:0]),
    .cnt_i   (cnt_q),
    .sum_o   (partial)
  );

  assign acc_sum = acc_q + partial;

  // NOTE: every *_d gets a default before the case so no path leaves a
  // signal unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    z_d      = z_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = mult_mag(a, mult_signed);
          mplier_d = mult_mag(b, mult_signed);
          neg_d    = mult_signed & (a[MULT_WIDTH-1] ^ b[MULT_WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        cnt_d    = cnt_q + 1'b1;
        mplier_d = mplier_q >> MULT_BPC;
        if (cnt_q == LAST_CNT) begin
          z_d     = neg_q ? -acc_sum : acc_sum;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values; the datapath registers share the reset so
  // an abort never leaves a stale partial product visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign z    = z_q;

endmodule

// File: tb/tb_mult_iter4.sv
// Self-checking bench for mult_iter4: directed corner vectors plus random
// operands compared against a plain-arithmetic 64-bit product model.
module tb_mult_iter4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mult_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [63:0] z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_iter4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mult_signed (mult_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .z           (z)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Drives one operation starting at the current negedge; returns at the
  // first negedge where busy is low, with the busy-cycle count and whether z
  // held its previous value throughout.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                       output int cycles, output bit held);
    logic [63:0] prev;
    prev        = z;
    a           = x;
    b           = y;
    mult_signed = sgn;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    a           = $urandom;
    b           = $urandom;
    mult_signed = 1'($urandom);
    cycles      = 0;
    held        = 1'b1;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      if (z !== prev) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mult_signed = 1'b0; a = '0; b = '0;
    #12;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (z !== 64'd0) begin n_fail++; $display("FAIL reset_z: got %h expected 0", z); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    int cycles; bit held;
    do_op(32'hFFFF3F3F, 32'hFFFF7F7F, 1'b1, cycles, held);
    n_checks++;
    if (cycles != 8) begin n_fail++; $display("FAIL signed_busy_len: got %0d expected 8", cycles); end
    n_checks++;
    if (held !== 1'b1) begin n_fail++; $display("FAIL signed_z_hold: z changed while busy"); end
    n_checks++;
    if (z !== 64'h0000000060C1A141) begin
      n_fail++; $display("FAIL signed_prod: got %h expected 0000000060c1a141", z);
    end
    do_op(32'hFFFF3F3F, 32'hFFFF7F7F, 1'b0, cycles, held);
    n_checks++;
    if (cycles != 8) begin n_fail++; $display("FAIL unsigned_busy_len: got %0d expected 8", cycles); end
    n_checks++;
    if (held !== 1'b1) begin n_fail++; $display("FAIL unsigned_z_hold: z changed while busy"); end
    n_checks++;
    if (z !== 64'hFFFEBEBE60C1A141) begin
      n_fail++; $display("FAIL unsigned_prod: got %h expected fffebebe60c1a141", z);
    end
  endtask

  task automatic test_back_to_back();
    int cycles; bit held;
    for (int m = 1; m >= 0; m--) begin
      do_op(32'h111, 32'h777, 1'(m), cycles, held);
      n_checks++;
      if (cycles != 8) begin n_fail++; $display("FAIL b2b_busy_len m=%0d: got %0d expected 8", m, cycles); end
      n_checks++;
      if (z !== 64'h000000000007F5E7) begin
        n_fail++; $display("FAIL b2b_prod m=%0d: got %h expected 000000000007f5e7", m, z);
      end
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  task automatic test_corners();
    vec_t v [6];
    int cycles; bit held;
    v[0] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    v[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
    v[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    v[3] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0};
    v[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1};
    v[5] = '{32'h12345678, 32'h00000000, 1'b0, 64'h0};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].x, v[i].y, v[i].sgn, cycles, held);
      n_checks++;
      if (z !== v[i].exp) begin
        n_fail++; $display("FAIL corner_%0d: got %h expected %h", i, z, v[i].exp);
      end
      n_checks++;
      if (cycles != 8) begin n_fail++; $display("FAIL corner_len_%0d: got %0d expected 8", i, cycles); end
    end
  endtask

  task automatic test_start_ignored();
    int cycles;
    a = 32'h0000BEEF; b = 32'hFFFFFFF3; mult_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      if (cycles == 3) begin
        start = 1'b1; a = 32'h00000005; b = 32'h00000007; mult_signed = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (cycles != 8) begin n_fail++; $display("FAIL ignore_busy_len: got %0d expected 8", cycles); end
    n_checks++;
    if (z !== ref_prod(32'h0000BEEF, 32'hFFFFFFF3, 1'b1)) begin
      n_fail++; $display("FAIL ignore_prod: got %h expected %h", z, ref_prod(32'h0000BEEF, 32'hFFFFFFF3, 1'b1));
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cycles; bit held;
    a = 32'h7FFF0001; b = 32'h00030009; mult_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++;
    if (z !== 64'd0) begin n_fail++; $display("FAIL midrst_z: got %h expected 0", z); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || z !== 64'd0) begin
      n_fail++; $display("FAIL midrst_idle: busy=%b z=%h expected 0/0", busy, z);
    end
    do_op(32'hFFFFFF9C, 32'h00000C35, 1'b1, cycles, held);
    n_checks++;
    if (z !== 64'hFFFFFFFFFFFB3B4C) begin
      n_fail++; $display("FAIL midrst_fresh: got %h expected fffffffffffb3b4c", z);
    end
    n_checks++;
    if (cycles != 8) begin n_fail++; $display("FAIL midrst_len: got %0d expected 8", cycles); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int cycles; bit held;
    logic [31:0] x, y;
    logic sgn;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      x = pick_operand();
      y = pick_operand();
      sgn = 1'($urandom);
      exp = ref_prod(x, y, sgn);
      do_op(x, y, sgn, cycles, held);
      n_checks++;
      if (z !== exp) begin
        n_fail++; $display("FAIL rand_%0d %h*%h s=%b: got %h expected %h", i, x, y, sgn, z, exp);
      end
      n_checks++;
      if (cycles != 8 || held !== 1'b1) begin
        n_fail++; $display("FAIL rand_ctl_%0d: busy cycles %0d held %b, expected 8 and 1", i, cycles, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_corners();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_iter4.md
Name: mult_iter4

Overview:
- Multi-cycle 32x32 -> 64-bit integer multiplier for the multi-cycle MIPS datapath; serves MULT and MULTU.
- The controller pulses `start` with `mult_signed` and waits while `busy` is high; HI/LO are then written from `z[63:32]` and `z[31:0]`.
- Processes 4 multiplier bits per cycle, so one operation takes 8 iterations.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- BITS_PER_CYCLE, 4, multiplier bits consumed per iteration.
- ITERS, WIDTH/BITS_PER_CYCLE = 8, iteration count; the counter is 3 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request; sampled only when busy=0.
- mult_signed  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- a  in  32  multiplicand; sampled with start.
- b  in  32  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress.
- z  out  64  product; holds the last result until the next result is written.

Behaviour:
- Reset: rst=0 asynchronously clears busy, z, the accumulator, the counter (cnt=0) and the operand/sign registers.
- Idle (busy=0) with start=1 at edge N:
  - Latch the operands. If mult_signed=1, latch |a| and |b| and neg = a[31]^b[31]; otherwise latch a and b unchanged and neg=0.
  - |0x80000000| = 0x80000000, treated as an unsigned magnitude.
  - Clear the accumulator; set cnt=0; busy=1 from edge N.
- Each busy cycle (8 in total, edges N+1..N+8):
  - Form 4 partial products s_0..s_3 = mcand AND {64{mplier bit i}}, for the next 4 multiplier bits starting at the LSB.
  - Shift each s_i left by i, then by 4*cnt.
  - Reduce them with a 2-level adder tree (add1_0_1 = s_0+s_1, add1_2_3 = s_2+s_3, then the sum of both).
  - Add the tree result into the 64-bit accumulator; cnt increments.
- Final iteration (cnt=7, edge N+8):
  - z <= neg ? -(accumulator+partial) : (accumulator+partial), in 64-bit two's complement.
  - busy <= 0, cnt <= 0.
- Latency: z is valid and busy=0 after the 8th busy edge. A new start is accepted on the very next cycle.
- start while busy=1 is ignored; operands and mode are not re-sampled.
- a, b and mult_signed may change freely after the start cycle.
- z changes only at the completion edge or on reset. While busy, z keeps the previous result.
- Reset asserted mid-operation aborts the operation; no partial result is ever written to z.
- Arithmetic is exact over the full 64 bits, including the corner cases 0x80000000 x 0x80000000 and -1 x -1; there is no overflow.

Decomposition:
- Shared package mult_pkg: MULT_WIDTH=32, MULT_BPC=4, MULT_ITERS=8, MULT_CNT_W=3.
- One sub-module, mult_pp4_adder: purely combinational.
  - Inputs: mcand (32), 4 multiplier bits, shift amount (cnt).
  - Output: a 64-bit shifted sum of the 4 partial products.
- Top level holds the control, counter, magnitude/sign logic and final negation.

Test Plan:
- Signed product: a=0xFFFF3F3F, b=0xFFFF7F7F, mult_signed=1, start pulse.
  - busy high for exactly 8 cycles.
  - z=0x0000000060C1A141.
- Unsigned product: same a and b with mult_signed=0 -> z=0xFFFEBEBE60C1A141.
- Back-to-back small operands: after completion, a=0x111, b=0x777, start on the next cycle -> z=0x000000000007F5E7 (both modes).
- Corner values:
  - signed 0x80000000 x 0x80000000 -> 0x4000000000000000.
  - signed 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFFFFFFFFFF.
  - unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001.
  - 0 x anything -> 0.
- start pulsed again mid-operation with different a and b:
  - The pulse is ignored and the first result is delivered unchanged.
  - busy still falls 8 cycles after the original start.
- rst driven low at cycle 4 of an operation:
  - busy=0 and z=0 immediately.
  - After release, a fresh start yields the correct product.
